// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the digit-serial subtract controller.
// Holds the FSM encoding, the slice width and the pass-count helper.
package serial_sub_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sub_state_t;

   localparam int SLICE_W = 4;

   function automatic int nib_count(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/serial_sub_ctrl_slice4.sv
// Combinational 4-bit subtract slice: s = a + ~b + cin, carry out on cout.
// A carry out of 1 means no borrow was generated by this nibble.
module sub_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] sum;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, ~b} + 5'(cin);
      s    = sum[3:0];
      cout = sum[4];
   end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Digit-serial WIDTH-bit subtractor: one 4-bit slice reused LS nibble first,
// inter-nibble borrow kept in borrow_r, result held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one nibble per cycle through the slice, NIB cycles total
// DONE  | single-cycle done pulse, then back to IDLE
import serial_sub_ctrl_pkg::*;

module serial_sub_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
);

   localparam int NIB = nib_count(WIDTH);
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   sub_state_t       state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             borrow_r;

   logic [3:0]       slice_s;
   logic             slice_cout;
   logic [WIDTH-1:0] res_next;

   sub_slice4 u_slice (
      .a    (opa[SLICE_W-1:0]),
      .b    (opb[SLICE_W-1:0]),
      .cin  (~borrow_r),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // New nibble enters at the top so the LS nibble lands at bit 0 after NIB passes.
   always_comb begin
      res_next = (res >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         opa      <= '0;
         opb      <= '0;
         res      <= '0;
         cnt      <= '0;
         borrow_r <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
         zero     <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  opa      <= a;
                  opb      <= b;
                  borrow_r <= bin;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               opa      <= opa >> SLICE_W;
               opb      <= opb >> SLICE_W;
               res      <= res_next;
               borrow_r <= ~slice_cout;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  diff  <= res_next;
                  bout  <= ~slice_cout;
                  zero  <= (res_next == '0);
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=16 and WIDTH=4.
module tb_serial_sub_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start16, bin16, busy16, done16, bout16, zero16;
   logic [15:0] a16, b16, diff16;
   logic        start4, bin4, busy4, done4, bout4, zero4;
   logic [3:0]  a4, b4, diff4;

   int checks = 0;
   int errors = 0;

   serial_sub_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
      .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16)
   );

   serial_sub_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_busy(input bit w4);
      return w4 ? busy4 : busy16;
   endfunction

   function automatic logic sel_done(input bit w4);
      return w4 ? done4 : done16;
   endfunction

   function automatic logic [15:0] sel_diff(input bit w4);
      return w4 ? {12'h000, diff4} : diff16;
   endfunction

   function automatic logic sel_bout(input bit w4);
      return w4 ? bout4 : bout16;
   endfunction

   function automatic logic sel_zero(input bit w4);
      return w4 ? zero4 : zero16;
   endfunction

   // Launch one operation and check latency, busy length and results.
   task automatic run_op(input string tag, input bit w4,
                         input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         input logic [15:0] ed, input logic eb, input logic ez,
                         input int exp_edges);
      int edges;
      int busy_cnt;
      int overlap;
      edges = 0; busy_cnt = 0; overlap = 0;
      if (w4) begin
         a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi; start4 = 1'b1;
      end else begin
         a16 = av; b16 = bv; bin16 = bi; start16 = 1'b1;
      end
      tick();
      edges = 1;
      start4 = 1'b0; start16 = 1'b0;
      while (!sel_done(w4) && edges < 40) begin
         if (sel_busy(w4)) busy_cnt++;
         tick();
         edges++;
      end
      if (sel_busy(w4) && sel_done(w4)) overlap++;
      chk({tag, " edges"}, edges, exp_edges);
      chk({tag, " busy_cycles"}, busy_cnt, exp_edges - 1);
      chk({tag, " busy_done_overlap"}, overlap, 0);
      chk({tag, " diff"}, sel_diff(w4), ed);
      chk({tag, " bout"}, sel_bout(w4), eb);
      chk({tag, " zero"}, sel_zero(w4), ez);
      tick();
      chk({tag, " done_one_cycle"}, sel_done(w4), 1'b0);
      chk({tag, " diff_hold"}, sel_diff(w4), ed);
   endtask

   initial begin
      int seen_done;
      rst = 1'b1;
      start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      tick(); tick();
      rst = 1'b0;

      chk("rst busy", busy16, 1'b0);
      chk("rst done", done16, 1'b0);
      chk("rst diff", diff16, 16'h0000);
      chk("rst bout", bout16, 1'b0);
      chk("rst zero", zero16, 1'b1);
      chk("rst4 zero", zero4, 1'b1);

      run_op("sub_basic", 1'b0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 5);
      run_op("sub_under", 1'b0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 5);
      run_op("sub_equal", 1'b0, 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 5);
      run_op("sub_bin",   1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 5);
      run_op("sub_bin2",  1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 1'b0, 5);

      run_op("w4_a", 1'b1, 16'h000D, 16'h000B, 1'b0, 16'h0002, 1'b0, 1'b0, 2);
      run_op("w4_b", 1'b1, 16'h0009, 16'h000F, 1'b0, 16'h000A, 1'b1, 1'b0, 2);

      // Start held high with operands changing after acceptance.
      a16 = 16'h5000; b16 = 16'h1000; bin16 = 1'b0; start16 = 1'b1;
      tick();
      a16 = 16'h0FFF; b16 = 16'h0001; bin16 = 1'b1;
      tick();
      bin16 = 1'b0;
      chk("hold busy", busy16, 1'b1);
      chk("hold prior diff", diff16, 16'h7FFE);
      tick(); tick(); tick();
      chk("hold done1", done16, 1'b1);
      chk("hold diff1", diff16, 16'h4000);
      tick();
      chk("hold drop_in_done", busy16, 1'b0);
      tick();
      chk("hold accept", busy16, 1'b1);
      start16 = 1'b0;
      a16 = 16'hFFFF; b16 = 16'h0000;
      tick();
      chk("hold diff_in_run", diff16, 16'h4000);
      tick(); tick(); tick();
      chk("hold done2", done16, 1'b1);
      chk("hold diff2", diff16, 16'h0FFE);
      tick();

      // Reset during the second RUN cycle aborts with no done pulse.
      a16 = 16'h1234; b16 = 16'h0234; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", busy16, 1'b0);
      chk("abort done", done16, 1'b0);
      chk("abort diff", diff16, 16'h0000);
      chk("abort zero", zero16, 1'b1);
      seen_done = 0;
      for (int i = 0; i < 6; i++) begin
         if (done16) seen_done++;
         tick();
      end
      chk("abort no_done", seen_done, 0);
      run_op("after_abort", 1'b0, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
